// File: rtl/dla_clock_cross_req_arbiter_pkg.sv
// Shared types and helpers for the round-robin clock-crossing request arbiter.
// Holds the FSM state encoding and the find-first-from-pointer search.
package dla_clock_cross_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACK_HI = 2'd1,
    WAIT_ACK_LO = 2'd2
  } state_t;

  // Upper bound on requesters the search function can scan.
  localparam int RR_MAX   = 64;
  localparam int RR_IDX_W = 6;

  // Returns the first set bit of valid at or after ptr (wrapping within n), or -1.
  // Scanning from the far end lets the nearest candidate overwrite the result.
  function automatic int rr_pick(input logic [RR_MAX-1:0] valid, input int ptr, input int n);
    int idx;
    rr_pick = -1;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (valid[idx[RR_IDX_W-1:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/dla_clock_cross_half_sync.sv
// Multi-flop level synchronizer for a signal arriving from another clock domain.
// Cleared asynchronously by an active-low reset that the caller keeps synchronous to clk_dst.
module dla_clock_cross_half_sync
  import dla_clock_cross_req_arbiter_pkg::*;
#(
  parameter int METASTABILITY_STAGES = 3
) (
  input  logic clk_dst,
  input  logic i_dst_async_resetn,
  input  logic i_async,
  output logic o_sync
);

  logic [METASTABILITY_STAGES-1:0] sync_q;

  always_ff @(posedge clk_dst or negedge i_dst_async_resetn) begin
    if (!i_dst_async_resetn) sync_q <= '0;
    else                     sync_q <= {sync_q[METASTABILITY_STAGES-2:0], i_async};
  end

  assign o_sync = sync_q[METASTABILITY_STAGES-1];

endmodule

// File: rtl/dla_clock_cross_req_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack clock-crossing channel among NUM_REQ requesters.
// Optional handshake watchdog: define DLA_CLOCK_CROSS_REQ_ARBITER_WATCHDOG_EN.
module dla_clock_cross_req_arbiter
  import dla_clock_cross_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ              = 4,
  parameter int DATA_WIDTH           = 32,
  parameter int METASTABILITY_STAGES = 3,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input  logic                            clk,
  input  logic                            i_sclr,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic                            o_xfer_req,
  output logic [DATA_WIDTH-1:0]           o_xfer_data,
  output logic [$clog2(NUM_REQ)-1:0]      o_xfer_id,
  input  logic                            i_xfer_ack_async,
  output logic                            o_busy,
  output logic                            o_timeout
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > RR_MAX) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..%0d", RR_MAX);
  end
  if (METASTABILITY_STAGES < 2) begin : g_bad_stages
    $error("METASTABILITY_STAGES must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  state_t                state;
  state_t                state_next;
  logic                  sync_rst_n;
  logic                  ack_sync;
  logic [ID_W-1:0]       rr_ptr;
  logic [RR_MAX-1:0]     valid_ext;
  int                    pick;
  logic                  found;
  logic [ID_W-1:0]       winner;
  logic                  grant;
  logic [NUM_REQ-1:0]    ready;
  logic [DATA_WIDTH-1:0] win_data;

  // Registered release keeps the synchronizer reset aligned to clk edges.
  always_ff @(posedge clk) sync_rst_n <= ~i_sclr;

  dla_clock_cross_half_sync #(
    .METASTABILITY_STAGES(METASTABILITY_STAGES)
  ) u_ack_sync (
    .clk_dst           (clk),
    .i_dst_async_resetn(sync_rst_n),
    .i_async           (i_xfer_ack_async),
    .o_sync            (ack_sync)
  );

  assign valid_ext = RR_MAX'(i_req_valid);

  always_comb begin
    pick   = rr_pick(valid_ext, int'(rr_ptr), NUM_REQ);
    found  = (pick >= 0);
    winner = pick[ID_W-1:0];
  end

  assign win_data = i_req_data[winner*DATA_WIDTH +: DATA_WIDTH];

  // A stale high ack (e.g. left over from a reset mid-handshake) blocks new grants.
  always_comb begin
    state_next = state;
    ready      = '0;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (!ack_sync && found && !i_sclr) begin
          grant         = 1'b1;
          ready[winner] = 1'b1;
          state_next    = WAIT_ACK_HI;
        end
      end
      WAIT_ACK_HI: if (ack_sync)  state_next = WAIT_ACK_LO;
      WAIT_ACK_LO: if (!ack_sync) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state       <= IDLE;
      o_xfer_req  <= 1'b0;
      o_xfer_data <= '0;
      o_xfer_id   <= '0;
      rr_ptr      <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        o_xfer_req  <= 1'b1;
        o_xfer_data <= win_data;
        o_xfer_id   <= winner;
        rr_ptr      <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end else if (state == WAIT_ACK_HI && ack_sync) begin
        o_xfer_req <= 1'b0;
      end
    end
  end

  assign o_req_ready = ready;
  assign o_busy      = (state != IDLE);

`ifdef DLA_CLOCK_CROSS_REQ_ARBITER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  // Counter restarts on every state entry; the flag only reports, it never aborts the FSM.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_next != state) begin
        wd_cnt <= '0;
      end else if (state != IDLE && wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (state != IDLE && state_next == state && wd_cnt == WD_W'(TIMEOUT_CYCLES - 1))
        timeout_q <= 1'b1;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dla_clock_cross_req_arbiter.sv
// Scoreboard bench for the round-robin clock-crossing request arbiter.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dla_clock_cross_req_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int DW       = 32;
  localparam int STAGES   = 3;
  localparam int TIMEOUT  = 16;
  localparam int N_RANDOM = 1000;

  typedef struct {
    int          id;
    logic [31:0] d;
  } ent_t;

  logic                    clk = 1'b0;
  logic                    i_sclr = 1'b1;
  logic [NUM_REQ-1:0]      valid = '0;
  logic [NUM_REQ*DW-1:0]   data = '0;
  logic [NUM_REQ-1:0]      o_req_ready;
  logic                    o_xfer_req;
  logic [DW-1:0]           o_xfer_data;
  logic [1:0]              o_xfer_id;
  logic                    ack = 1'b0;
  logic                    o_busy;
  logic                    o_timeout;

  always #5 clk = ~clk;

  dla_clock_cross_req_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW),
    .METASTABILITY_STAGES(STAGES), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .i_sclr(i_sclr), .i_req_valid(valid), .i_req_data(data),
    .o_req_ready(o_req_ready), .o_xfer_req(o_xfer_req), .o_xfer_data(o_xfer_data),
    .o_xfer_id(o_xfer_id), .i_xfer_ack_async(ack), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  ent_t        sb[$];
  int          grant_log[$];
  int          n_grants = 0;
  logic [NUM_REQ-1:0] acc = '0;
  logic        pend = 1'b0;
  int          pend_id = 0;
  logic [DW-1:0] held = '0;
  logic        prev_busy = 1'b0;
  logic        cont = 1'b0;
  logic        rnd = 1'b0;
  int          n_offered = 0;
  int          seq = 0;
  logic        far_auto = 1'b0;
  logic        far_fixed = 1'b1;
  int          far_fix_lat = 2;
  int          far_lat = 2;
  int          far_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic offer(input int k, input logic [31:0] d);
    ent_t e;
    valid[k] = 1'b1;
    data[k*DW +: DW] = d;
    e.id = k;
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic withdraw(input int k);
    valid[k] = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].id == k) begin
        sb.delete(i);
        break;
      end
    end
  endtask

  task automatic monitor();
    int pos;
    int k;
    if (pend) begin
      pos = -1;
      for (int i = 0; i < sb.size(); i++) if (pos < 0 && sb[i].id == pend_id) pos = i;
      check("xfer_req_rise", o_xfer_req, 1);
      check("xfer_id", o_xfer_id, pend_id);
      check("sb_has_id", logic'(pos >= 0), 1'b1);
      if (pos >= 0) begin
        check("xfer_data", o_xfer_data, sb[pos].d);
        sb.delete(pos);
      end
      held = o_xfer_data;
      grant_log.push_back(pend_id);
      n_grants++;
      pend = 1'b0;
    end else if (o_busy && prev_busy) begin
      check("data_hold", o_xfer_data, held);
    end
    check("ready_onehot", $onehot0(o_req_ready), 1);
    if (o_busy) check("ready_busy", o_req_ready, 0);
    acc = o_req_ready;
    if (o_req_ready != '0) begin
      k = 0;
      for (int i = 0; i < NUM_REQ; i++) if (o_req_ready[i]) k = i;
      check("ready_valid", valid[k], 1);
      pend    = 1'b1;
      pend_id = k;
    end
    prev_busy = o_busy;
  endtask

  task automatic far_and_auto();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (acc[k]) begin
        valid[k] = 1'b0;
        if (cont) begin
          offer(k, {8'(k), 24'(seq)});
          seq++;
        end
      end
    end
    acc = '0;
    if (rnd) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!valid[k] && n_offered < N_RANDOM && $urandom_range(0, 3) == 0) begin
          offer(k, $urandom);
          n_offered++;
        end
      end
    end
    if (far_auto) begin
      if (o_xfer_req != ack) begin
        if (far_cnt >= far_lat) begin
          ack     = o_xfer_req;
          far_cnt = 0;
          far_lat = far_fixed ? far_fix_lat : int'($urandom_range(0, 20));
        end else begin
          far_cnt++;
        end
      end else begin
        far_cnt = 0;
      end
    end
  endtask

  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
    far_and_auto();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    i_sclr = 1'b1;
    ticks(2);
    i_sclr = 1'b0;
  endtask

  task automatic drain();
    int t;
    cont = 1'b0;
    rnd  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) if (valid[k]) withdraw(k);
    far_auto = 1'b1;
    t = 0;
    while ((o_busy || ack || pend || valid != '0) && t < 500) begin
      tick();
      t++;
    end
    check("drain_idle", logic'(t < 500), 1'b1);
  endtask

  initial begin
    int t;
    int cnt;
    int g0;
    @(negedge clk);
    // Reset values
    ticks(3);
    check("rst_ready", o_req_ready, 0);
    check("rst_req", o_xfer_req, 0);
    check("rst_data", o_xfer_data, 0);
    check("rst_id", o_xfer_id, 0);
    check("rst_busy", o_busy, 0);
    check("rst_timeout", o_timeout, 0);
    i_sclr = 1'b0;
    ticks(4);

    // Single requester 2, far ack two cycles after req
    far_auto = 1'b1; far_fixed = 1'b1; far_fix_lat = 2; far_lat = 2;
    offer(2, 32'hA5A5_0001);
    t = 0; while (!o_busy && t < 20) begin tick(); t++; end
    check("single_busy", o_busy, 1);
    check("single_id", o_xfer_id, 2);
    check("single_data", o_xfer_data, 32'hA5A5_0001);
    t = 0; while (!ack && t < 20) begin tick(); t++; end
    check("single_ack_seen", ack, 1);
    // Ack changes mid-cycle: first capture edge, then STAGES flops, then the req flop.
    cnt = 0; while (o_xfer_req && cnt < 20) begin tick(); cnt++; end
    check("req_fall_latency", cnt, STAGES + 1);
    check("data_after_req", o_xfer_data, 32'hA5A5_0001);
    t = 0; while (ack && t < 40) begin tick(); t++; end
    check("single_ack_low", ack, 0);
    ticks(STAGES);
    check("busy_before_idle", o_busy, 1);
    tick();
    check("idle_after_ack_low", o_busy, 0);
    drain();

    // Four continuous requesters, eight grants
    do_reset();
    far_fixed = 1'b0;
    cont = 1'b1;
    g0 = n_grants;
    for (int k = 0; k < NUM_REQ; k++) begin
      offer(k, {8'(k), 24'(seq)});
      seq++;
    end
    t = 0; while (n_grants < g0 + 8 && t < 2000) begin tick(); t++; end
    check("rr_eight_grants", logic'(n_grants >= g0 + 8), 1'b1);
    for (int i = 0; i < 8; i++)
      if (g0 + i < grant_log.size()) check("rr_order", grant_log[g0 + i], i % NUM_REQ);
    drain();

    // Reset in WAIT_ACK_HI with ack held high
    far_auto = 1'b0;
    offer(1, 32'h1111_0001);
    t = 0; while (!o_busy && t < 20) begin tick(); t++; end
    check("mid_busy", o_busy, 1);
    ack = 1'b1;
    tick();
    i_sclr = 1'b1;
    tick();
    check("mid_rst_req_drop", o_xfer_req, 0);
    check("mid_rst_busy", o_busy, 0);
    i_sclr = 1'b0;
    ticks(8);
    for (int k = 0; k < NUM_REQ; k++) offer(k, 32'h2222_0000 + 32'(k));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stale_no_grant", o_req_ready, 0);
      check("stale_idle", o_busy, 0);
    end
    ack = 1'b0;
    g0 = n_grants;
    t = 0; while (n_grants <= g0 && t < 30) begin tick(); t++; end
    check("post_rst_granted", logic'(n_grants > g0), 1'b1);
    if (n_grants > g0) check("post_rst_first_id", grant_log[g0], 0);
    drain();

    // Withdraw requester 1 while requester 3 arrives in the same cycle
    far_auto = 1'b0;
    ack = 1'b1;
    ticks(6);
    offer(1, 32'h3333_0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_off_ready", o_req_ready, 0);
    end
    withdraw(1);
    offer(3, 32'h3333_0003);
    ack = 1'b0;
    g0 = n_grants;
    t = 0;
    while (n_grants <= g0 && t < 30) begin
      tick();
      check("no_ready1", o_req_ready[1], 0);
      t++;
    end
    check("withdraw_granted", logic'(n_grants > g0), 1'b1);
    if (n_grants > g0) check("withdraw_grant_id", grant_log[g0], 3);
    drain();

    // Ack never returns
    do_reset();
    far_auto = 1'b0;
    offer(0, 32'h4444_0000);
    t = 0; while (!o_busy && t < 20) begin tick(); t++; end
    check("wd_busy", o_busy, 1);
`ifdef DLA_CLOCK_CROSS_REQ_ARBITER_WATCHDOG_EN
    ticks(TIMEOUT - 1);
    check("wd_before_limit", o_timeout, 0);
    tick();
    check("wd_at_limit", o_timeout, 1);
    ticks(5);
    check("wd_sticky", o_timeout, 1);
    i_sclr = 1'b1;
    tick();
    check("wd_cleared", o_timeout, 0);
    i_sclr = 1'b0;
`else
    for (int i = 0; i < 3 * TIMEOUT; i++) begin
      tick();
      if (i % TIMEOUT == TIMEOUT - 1) check("wd_off_zero", o_timeout, 0);
    end
    do_reset();
`endif
    drain();

    // Random far latency, random requesters
    far_auto = 1'b1;
    far_fixed = 1'b0;
    n_offered = 0;
    g0 = n_grants;
    rnd = 1'b1;
    t = 0; while (n_grants < g0 + N_RANDOM && t < 80000) begin tick(); t++; end
    check("random_grants", n_grants - g0, N_RANDOM);
    drain();
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

endmodule
